// File: rtl/i2c_pkg.sv
// ============================================================================
// Module : i2c_pkg
// Brief  : Shared I2C constants and state encoding for initiator and target
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package i2c_pkg;

    localparam int I2C_ADDR_W = 7;
    localparam int I2C_BYTE_W = 8;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ADDR      = 3'd1,
        ACK_A     = 3'd2,
        HI        = 3'd3,
        ACK_H     = 3'd4,
        LO        = 3'd5,
        ACK_L     = 3'd6,
        NACK_WAIT = 3'd7
    } i2c_state_e;

    // Address byte on the wire for a write to a 7-bit target address.
    function automatic logic [I2C_BYTE_W-1:0] i2c_write_byte(input logic [I2C_ADDR_W-1:0] addr);
        return {addr, 1'b0};
    endfunction

endpackage

`default_nettype wire

// File: rtl/i2c_line_sync.sv
// ============================================================================
// Module : i2c_line_sync
// Brief  : 2-flop synchronizer plus previous-value flop with edge detection
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module i2c_line_sync (
    input  logic clk,
    input  logic reset,
    input  logic line_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Flops reset to the idle-bus level so releasing reset never fakes an edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= line_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign level_o = sync_q;
    assign rise_o  = sync_q & ~prev_q;
    assign fall_o  = ~sync_q & prev_q;

endmodule

`default_nettype wire

// File: rtl/i2c_slave_rx.sv
// ============================================================================
// Module : i2c_slave_rx
// Brief  : I2C target accepting 3-byte writes (addr, hi, lo) -> 16-bit word
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module i2c_slave_rx
    import i2c_pkg::*;
#(
    parameter logic [I2C_ADDR_W-1:0] DEV_ADDR = 7'h1A
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        SCL,
    inout  wire         SDA,
    output logic [15:0] oDATA,
    output logic        oValid,
    output logic        oErr,
    output logic        oBusy
);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;
    logic start_det, stop_det;

    i2c_state_e             state_q, state_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic                   byte_full_q, byte_full_d;
    logic [I2C_BYTE_W-1:0]  shift_q, shift_d;
    logic [I2C_BYTE_W-1:0]  hi_q, hi_d;
    logic                   sda_low_q, sda_low_d;
    logic [15:0]            data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   err_q, err_d;
    logic                   busy_q, busy_d;

    i2c_line_sync u_scl_sync (
        .clk     (clk),
        .reset   (reset),
        .line_i  (SCL),
        .level_o (scl_lvl),
        .rise_o  (scl_rise),
        .fall_o  (scl_fall)
    );

    i2c_line_sync u_sda_sync (
        .clk     (clk),
        .reset   (reset),
        .line_i  (SDA),
        .level_o (sda_lvl),
        .rise_o  (sda_rise),
        .fall_o  (sda_fall)
    );

    assign start_det = sda_fall & scl_lvl;
    assign stop_det  = sda_rise & scl_lvl;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            bit_cnt_q   <= 3'd0;
            byte_full_q <= 1'b0;
            shift_q     <= '0;
            hi_q        <= '0;
            sda_low_q   <= 1'b0;
            data_q      <= 16'h0000;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            byte_full_q <= byte_full_d;
            shift_q     <= shift_d;
            hi_q        <= hi_d;
            sda_low_q   <= sda_low_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        byte_full_d = byte_full_q;
        shift_d     = shift_q;
        hi_d        = hi_q;
        sda_low_d   = sda_low_q;
        data_d      = data_q;
        valid_d     = 1'b0;
        err_d       = 1'b0;
        busy_d      = busy_q;

        if (start_det || stop_det) begin
            // Bus conditions override everything; a half-received word is dropped.
            if (state_q == HI || state_q == ACK_H || state_q == LO) begin
                err_d = 1'b1;
            end
            state_d     = start_det ? ADDR : IDLE;
            bit_cnt_d   = 3'd0;
            byte_full_d = 1'b0;
            sda_low_d   = 1'b0;
            busy_d      = 1'b0;
        end else begin
            case (state_q)
                ADDR, HI, LO: begin
                    if (scl_rise && !byte_full_q) begin
                        shift_d   = {shift_q[I2C_BYTE_W-2:0], sda_lvl};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            byte_full_d = 1'b1;
                        end
                    end else if (scl_fall && byte_full_q) begin
                        // Falling edge after the 8th bit opens the ACK slot.
                        byte_full_d = 1'b0;
                        bit_cnt_d   = 3'd0;
                        if (state_q == ADDR) begin
                            if (shift_q == i2c_write_byte(DEV_ADDR)) begin
                                state_d   = ACK_A;
                                sda_low_d = 1'b1;
                                busy_d    = 1'b1;
                            end else begin
                                state_d   = NACK_WAIT;
                            end
                        end else if (state_q == HI) begin
                            hi_d      = shift_q;
                            state_d   = ACK_H;
                            sda_low_d = 1'b1;
                        end else begin
                            data_d    = {hi_q, shift_q};
                            valid_d   = 1'b1;
                            state_d   = ACK_L;
                            sda_low_d = 1'b1;
                        end
                    end
                end
                ACK_A, ACK_H, ACK_L: begin
                    if (scl_fall) begin
                        sda_low_d = 1'b0;
                        bit_cnt_d = 3'd0;
                        case (state_q)
                            ACK_A:   state_d = HI;
                            ACK_H:   state_d = LO;
                            default: state_d = NACK_WAIT;
                        endcase
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Open-drain: only ever pull low, the async reset of sda_low_q releases at once.
    assign SDA    = sda_low_q ? I2C_ACK : 1'bz;
    assign oDATA  = data_q;
    assign oValid = valid_q;
    assign oErr   = err_q;
    assign oBusy  = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_i2c_slave_rx.sv
// ============================================================================
// Module : tb_i2c_slave_rx
// Brief  : Directed self-checking bench for i2c_slave_rx with pull-up SDA
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_i2c_slave_rx;
    import i2c_pkg::*;

    localparam int CLK_HALF = 10;   // 50 MHz system clock
    localparam int Q        = 200;  // SCL quarter period; SCL = 20 clk per bit half

    logic        clk     = 1'b0;
    logic        reset_n = 1'b0;
    logic        scl     = 1'b1;
    logic        m_sda   = 1'b1;    // 1 = initiator releases SDA
    wire         sda_bus;
    logic [15:0] odata;
    logic        ovalid, oerr, obusy;

    int tests = 0;
    int fails = 0;
    int valid_cnt = 0;
    int err_cnt = 0;
    int low_cnt = 0;

    assign sda_bus = m_sda ? 1'bz : 1'b0;
    pullup (sda_bus);

    i2c_slave_rx #(.DEV_ADDR(7'h1A)) dut (
        .clk    (clk),
        .reset  (reset_n),
        .SCL    (scl),
        .SDA    (sda_bus),
        .oDATA  (odata),
        .oValid (ovalid),
        .oErr   (oerr),
        .oBusy  (obusy)
    );

    always #CLK_HALF clk = ~clk;

    // Pulse and target-drive monitors, sampled away from the active edge.
    always @(negedge clk) begin
        if (ovalid === 1'b1) valid_cnt++;
        if (oerr === 1'b1) err_cnt++;
        if (m_sda && sda_bus === 1'b0) low_cnt++;
    end

    task automatic bus_start();
        m_sda = 1'b1; #Q;
        scl   = 1'b1; #Q;
        m_sda = 1'b0; #Q;
        scl   = 1'b0; #Q;
    endtask

    task automatic bus_stop();
        m_sda = 1'b0; #Q;
        scl   = 1'b1; #Q;
        m_sda = 1'b1; #(2*Q);
    endtask

    task automatic send_bits(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            m_sda = b[i]; #Q;
            scl   = 1'b1; #(2*Q);
            scl   = 1'b0; #Q;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack_low);
        send_bits(b);
        m_sda = 1'b1; #Q;
        scl   = 1'b1; #Q;
        ack_low = (sda_bus === 1'b0);
        #Q;
        scl   = 1'b0; #Q;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        tests++; if (odata !== 16'h0000) begin fails++; $display("FAIL reset_odata: got %h want 0000", odata); end
        tests++; if (ovalid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", ovalid); end
        tests++; if (oerr !== 1'b0) begin fails++; $display("FAIL reset_err: got %b want 0", oerr); end
        tests++; if (obusy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", obusy); end
        tests++; if (sda_bus !== 1'b1) begin fails++; $display("FAIL reset_sda: got %b want 1 (released)", sda_bus); end
        reset_n = 1'b1;
        repeat (4) @(posedge clk);
    endtask

    task automatic test_write();
        logic a0, a1, a2;
        int v0, e0;
        v0 = valid_cnt; e0 = err_cnt;
        bus_start();
        send_byte(8'h34, a0);
        tests++; if (obusy !== 1'b1) begin fails++; $display("FAIL write_busy: got %b want 1", obusy); end
        send_byte(8'h1E, a1);
        send_byte(8'h00, a2);
        bus_stop();
        tests++; if ({a0, a1, a2} !== 3'b111) begin fails++; $display("FAIL write_acks: got %b want 111", {a0, a1, a2}); end
        tests++; if (odata !== 16'h1E00) begin fails++; $display("FAIL write_odata: got %h want 1e00", odata); end
        tests++; if (valid_cnt - v0 !== 1) begin fails++; $display("FAIL write_valid_pulses: got %0d want 1", valid_cnt - v0); end
        tests++; if (err_cnt - e0 !== 0) begin fails++; $display("FAIL write_err_pulses: got %0d want 0", err_cnt - e0); end
        tests++; if (obusy !== 1'b0) begin fails++; $display("FAIL write_busy_after_stop: got %b want 0", obusy); end
    endtask

    task automatic test_wrong_addr();
        logic a0, a1;
        int v0, e0, l0;
        v0 = valid_cnt; e0 = err_cnt; l0 = low_cnt;
        bus_start();
        send_byte(8'h36, a0);
        tests++; if (obusy !== 1'b0) begin fails++; $display("FAIL wrong_busy: got %b want 0", obusy); end
        send_byte(8'hAA, a1);
        bus_stop();
        tests++; if (low_cnt - l0 !== 0) begin fails++; $display("FAIL wrong_sda_low: got %0d cycles want 0", low_cnt - l0); end
        tests++; if ({a0, a1} !== 2'b00) begin fails++; $display("FAIL wrong_acks: got %b want 00", {a0, a1}); end
        tests++; if (valid_cnt - v0 !== 0 || err_cnt - e0 !== 0) begin fails++; $display("FAIL wrong_pulses: got valid %0d err %0d want 0 0", valid_cnt - v0, err_cnt - e0); end
        tests++; if (odata !== 16'h1E00) begin fails++; $display("FAIL wrong_odata: got %h want 1e00", odata); end
    endtask

    task automatic test_read_addr();
        logic a0, a1;
        int v0, e0, l0;
        v0 = valid_cnt; e0 = err_cnt; l0 = low_cnt;
        bus_start();
        send_byte(8'h35, a0);
        tests++; if (a0 !== 1'b0) begin fails++; $display("FAIL read_ack: got %b want 0 (NACK)", a0); end
        tests++; if (dut.state_q !== NACK_WAIT) begin fails++; $display("FAIL read_state: got %0d want %0d", dut.state_q, NACK_WAIT); end
        send_byte(8'h55, a1);
        tests++; if (dut.state_q !== NACK_WAIT) begin fails++; $display("FAIL read_state_hold: got %0d want %0d", dut.state_q, NACK_WAIT); end
        bus_stop();
        tests++; if (dut.state_q !== IDLE) begin fails++; $display("FAIL read_state_stop: got %0d want %0d", dut.state_q, IDLE); end
        tests++; if (low_cnt - l0 !== 0 || valid_cnt - v0 !== 0 || err_cnt - e0 !== 0 || obusy !== 1'b0) begin
            fails++; $display("FAIL read_outputs: got low %0d valid %0d err %0d busy %b want 0 0 0 0", low_cnt - l0, valid_cnt - v0, err_cnt - e0, obusy);
        end
    endtask

    task automatic test_partial();
        logic a0, a1;
        int v0, e0;
        v0 = valid_cnt; e0 = err_cnt;
        bus_start();
        send_byte(8'h34, a0);
        send_byte(8'h12, a1);
        bus_stop();
        tests++; if ({a0, a1} !== 2'b11) begin fails++; $display("FAIL partial_acks: got %b want 11", {a0, a1}); end
        tests++; if (err_cnt - e0 !== 1) begin fails++; $display("FAIL partial_err_pulses: got %0d want 1", err_cnt - e0); end
        tests++; if (valid_cnt - v0 !== 0) begin fails++; $display("FAIL partial_valid: got %0d want 0", valid_cnt - v0); end
        tests++; if (odata !== 16'h1E00) begin fails++; $display("FAIL partial_odata: got %h want 1e00", odata); end
        tests++; if (obusy !== 1'b0) begin fails++; $display("FAIL partial_busy: got %b want 0", obusy); end
    endtask

    task automatic test_back_to_back();
        logic a0, a1, a2, a3, a4, a5;
        int v0, e0;
        v0 = valid_cnt; e0 = err_cnt;
        bus_start();
        send_byte(8'h34, a0);
        send_byte(8'h12, a1);
        bus_start();
        send_byte(8'h34, a2);
        send_byte(8'hAB, a3);
        send_byte(8'hCD, a4);
        bus_stop();
        tests++; if ({a0, a1, a2, a3, a4} !== 5'b11111) begin fails++; $display("FAIL restart_acks: got %b want 11111", {a0, a1, a2, a3, a4}); end
        tests++; if (err_cnt - e0 !== 1) begin fails++; $display("FAIL restart_err_pulses: got %0d want 1", err_cnt - e0); end
        tests++; if (valid_cnt - v0 !== 1) begin fails++; $display("FAIL restart_valid_pulses: got %0d want 1", valid_cnt - v0); end
        tests++; if (odata !== 16'hABCD) begin fails++; $display("FAIL restart_odata: got %h want abcd", odata); end

        v0 = valid_cnt; e0 = err_cnt;
        bus_start();
        send_byte(8'h34, a0);
        send_byte(8'h11, a1);
        send_byte(8'h22, a2);
        send_byte(8'hFF, a5);
        bus_stop();
        tests++; if ({a0, a1, a2} !== 3'b111) begin fails++; $display("FAIL extra_acks: got %b want 111", {a0, a1, a2}); end
        tests++; if (a5 !== 1'b0) begin fails++; $display("FAIL extra_byte_ack: got %b want 0 (NACK)", a5); end
        tests++; if (odata !== 16'h1122) begin fails++; $display("FAIL extra_odata: got %h want 1122", odata); end
        tests++; if (valid_cnt - v0 !== 1 || err_cnt - e0 !== 0) begin fails++; $display("FAIL extra_pulses: got valid %0d err %0d want 1 0", valid_cnt - v0, err_cnt - e0); end
    endtask

    task automatic test_reset_mid_ack();
        logic a0, a1, a2, a3;
        int v0;
        bus_start();
        send_byte(8'h34, a0);
        send_bits(8'h12);
        m_sda = 1'b1; #Q;
        scl   = 1'b1; #(Q/2);
        tests++; if (sda_bus !== 1'b0) begin fails++; $display("FAIL midack_sda_held: got %b want 0", sda_bus); end
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        tests++; if (sda_bus !== 1'b1) begin fails++; $display("FAIL midack_sda_release: got %b want 1 (released)", sda_bus); end
        tests++; if (odata !== 16'h0000 || ovalid !== 1'b0 || oerr !== 1'b0 || obusy !== 1'b0) begin
            fails++; $display("FAIL midack_outputs: got data %h valid %b err %b busy %b want 0000 0 0 0", odata, ovalid, oerr, obusy);
        end
        #40;
        reset_n = 1'b1;
        #(Q/2);
        scl = 1'b0; #Q;
        bus_stop();
        v0 = valid_cnt;
        bus_start();
        send_byte(8'h34, a1);
        send_byte(8'h5A, a2);
        send_byte(8'hC3, a3);
        bus_stop();
        tests++; if ({a1, a2, a3} !== 3'b111) begin fails++; $display("FAIL after_reset_acks: got %b want 111", {a1, a2, a3}); end
        tests++; if (odata !== 16'h5AC3) begin fails++; $display("FAIL after_reset_odata: got %h want 5ac3", odata); end
        tests++; if (valid_cnt - v0 !== 1) begin fails++; $display("FAIL after_reset_valid: got %0d want 1", valid_cnt - v0); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_wrong_addr();
        test_read_addr();
        test_partial();
        test_back_to_back();
        test_reset_mid_ack();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
